ps2_digit_receiver: RTL and testbench



---
 rtl/ps2_digit_receiver_pkg.sv | 21 ++
 rtl/ps2_digit_receiver_if.sv | 10 +
 rtl/ps2_frame_rx.sv | 80 ++++++++
 rtl/ps2_digit_receiver.sv | 53 +++++
 tb/tb_ps2_digit_receiver.sv | 122 ++++++++++++
 5 files changed

// File: rtl/ps2_digit_receiver_pkg.sv
// ps2_pkg: frame FSM states, PS/2 prefix codes and digit scan-code lookup
package ps2_pkg;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_t;
  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT = 8'hE0;
  function automatic logic [4:0] scan_to_digit(input logic [7:0] sc);
    case (sc)
      8'h45: return {1'b1, 4'd0};
      8'h16: return {1'b1, 4'd1};
      8'h1E: return {1'b1, 4'd2};
      8'h26: return {1'b1, 4'd3};
      8'h25: return {1'b1, 4'd4};
      8'h2E: return {1'b1, 4'd5};
      8'h36: return {1'b1, 4'd6};
      8'h3D: return {1'b1, 4'd7};
      8'h3E: return {1'b1, 4'd8};
      8'h46: return {1'b1, 4'd9};
      default: return 5'd0;
    endcase
  endfunction
endpackage

// File: rtl/ps2_digit_receiver_if.sv
// ps2_digit_receiver_if: decoded digit pair, scan byte and status pulses
interface ps2_digit_receiver_if;
  logic [3:0] o_num1;
  logic [3:0] o_num2;
  logic o_valid;
  logic [7:0] o_scan;
  logic o_err;
  modport master(output o_num1, o_num2, o_valid, o_scan, o_err);
  modport slave(input o_num1, o_num2, o_valid, o_scan, o_err);
endinterface

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: synchronises PS/2 pins and validates 11-bit frames into byte strobes
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 12000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic [7:0] rx_byte,
  output logic       strobe,
  output logic       err
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [1:0] clk_s, dat_s;
  logic clk_d, fall, dat;
  ps2_state_t state;
  logic [2:0] cnt;
  logic [7:0] sh;
  logic par;
  logic [TW-1:0] tmo;
  assign fall = clk_d & ~clk_s[1];
  assign dat = dat_s[1];
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      clk_s <= 2'b11;
      dat_s <= 2'b11;
      clk_d <= 1'b1;
    end else begin
      clk_s <= {clk_s[0], i_ps2_clk};
      dat_s <= {dat_s[0], i_ps2_data};
      clk_d <= clk_s[1];
    end
  // An edge always wins over a timeout expiring in the same cycle
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state <= IDLE;
      cnt <= '0;
      sh <= '0;
      par <= 1'b0;
      tmo <= '0;
      rx_byte <= '0;
      strobe <= 1'b0;
      err <= 1'b0;
    end else begin
      strobe <= 1'b0;
      err <= 1'b0;
      if (fall) begin
        tmo <= '0;
        case (state)
          IDLE: if (!dat) begin
            state <= DATA;
            cnt <= '0;
          end
          DATA: begin
            sh <= {dat, sh[7:1]};
            cnt <= cnt + 3'd1;
            if (cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par <= dat;
            state <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (dat && (^sh ^ par)) begin
              rx_byte <= sh;
              strobe <= 1'b1;
            end else err <= 1'b1;
          end
        endcase
      end else if (state == IDLE) tmo <= '0;
      else if (tmo == TW'(TIMEOUT_CYCLES - 1)) begin
        state <= IDLE;
        tmo <= '0;
        err <= 1'b1;
      end else tmo <= tmo + 1'b1;
    end
endmodule

// File: rtl/ps2_digit_receiver.sv
// ps2_digit_receiver: strips break/extended sequences and shifts pressed digits into a pair
module ps2_digit_receiver
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 12000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_ps2_clk,
  input  logic i_ps2_data,
  ps2_digit_receiver_if.master dig
);
  logic [7:0] rx_byte;
  logic strobe, rx_err, brk, ext;
  logic [4:0] hd;
  ps2_frame_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .i_ps2_clk(i_ps2_clk),
    .i_ps2_data(i_ps2_data),
    .rx_byte(rx_byte),
    .strobe(strobe),
    .err(rx_err)
  );
  assign hd = scan_to_digit(rx_byte);
  // The byte after a prefix is swallowed whatever it is, then both flags clear
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      brk <= 1'b0;
      ext <= 1'b0;
      dig.o_num1 <= '0;
      dig.o_num2 <= '0;
      dig.o_scan <= '0;
      dig.o_valid <= 1'b0;
      dig.o_err <= 1'b0;
    end else begin
      dig.o_valid <= 1'b0;
      dig.o_err <= rx_err;
      if (strobe) begin
        dig.o_scan <= rx_byte;
        if (rx_byte == PS2_BREAK) brk <= 1'b1;
        else if (rx_byte == PS2_EXT) ext <= 1'b1;
        else if (brk || ext) begin
          brk <= 1'b0;
          ext <= 1'b0;
        end else if (hd[4]) begin
          dig.o_num2 <= dig.o_num1;
          dig.o_num1 <= hd[3:0];
          dig.o_valid <= 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_ps2_digit_receiver.sv
// tb_ps2_digit_receiver: table-driven PS/2 frame vectors plus error, timeout and reset sequences
module tb_ps2_digit_receiver;
  localparam int TMO = 200;
  localparam int HALF = 8;
  logic clk = 1'b0, rst_n = 1'b0, ps2_clk = 1'b1, ps2_dat = 1'b1;
  int total = 0, passed = 0, nv = 0, ne = 0, bad = 0;
  logic pv = 1'b0, pe = 1'b0;
  ps2_digit_receiver_if dig();
  ps2_digit_receiver #(.TIMEOUT_CYCLES(TMO)) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_ps2_clk(ps2_clk),
    .i_ps2_data(ps2_dat),
    .dig(dig)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (rst_n) begin
      if (dig.o_valid) nv++;
      if (dig.o_err) ne++;
      if ((dig.o_valid && dig.o_err) || (dig.o_valid && pv) || (dig.o_err && pe)) bad++;
    end
    pv = dig.o_valid;
    pe = dig.o_err;
  end
  typedef struct {
    int n;
    logic [7:0] b [3];
    logic [3:0] n1;
    logic [3:0] n2;
    logic [7:0] sc;
    int v;
  } vec_t;
  vec_t vecs [7];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic ps2_bit(input logic b);
    @(negedge clk) ps2_dat = b;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask
  task automatic send(input logic [7:0] b, input logic flip, input logic stop);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(~^b ^ flip);
    ps2_bit(stop);
    ps2_dat = 1'b1;
    repeat (2 * HALF) @(negedge clk);
  endtask
  task automatic check_out(input string name, input logic [3:0] n1, input logic [3:0] n2, input logic [7:0] sc);
    check({name, ".num1"}, 32'(dig.o_num1), 32'(n1));
    check({name, ".num2"}, 32'(dig.o_num2), 32'(n2));
    check({name, ".scan"}, 32'(dig.o_scan), 32'(sc));
  endtask
  initial begin
    int v0, e0;
    vecs[0] = '{2, '{8'h16, 8'h1E, 8'h00}, 4'd2, 4'd1, 8'h1E, 2};
    vecs[1] = '{3, '{8'h45, 8'hF0, 8'h45}, 4'd0, 4'd2, 8'h45, 1};
    vecs[2] = '{3, '{8'hE0, 8'h16, 8'h46}, 4'd9, 4'd0, 8'h46, 1};
    vecs[3] = '{1, '{8'h36, 8'h00, 8'h00}, 4'd6, 4'd9, 8'h36, 1};
    vecs[4] = '{3, '{8'hF0, 8'h36, 8'h3E}, 4'd8, 4'd6, 8'h3E, 1};
    vecs[5] = '{1, '{8'h1C, 8'h00, 8'h00}, 4'd8, 4'd6, 8'h1C, 0};
    vecs[6] = '{2, '{8'h2E, 8'h2E, 8'h00}, 4'd5, 4'd5, 8'h2E, 2};
    repeat (5) @(negedge clk);
    check("reset_state", {16'd0, dig.o_num1, dig.o_num2, dig.o_scan}, 32'd0);
    check("reset_pulses", {30'd0, dig.o_valid, dig.o_err}, 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    for (int k = 0; k < 7; k++) begin
      v0 = nv;
      e0 = ne;
      for (int j = 0; j < vecs[k].n; j++) send(vecs[k].b[j], 1'b0, 1'b1);
      check_out($sformatf("vec%0d", k), vecs[k].n1, vecs[k].n2, vecs[k].sc);
      check($sformatf("vec%0d.valid_cnt", k), 32'(nv - v0), 32'(vecs[k].v));
      check($sformatf("vec%0d.err_cnt", k), 32'(ne - e0), 32'd0);
    end
    v0 = nv;
    e0 = ne;
    send(8'h26, 1'b1, 1'b1);
    check("parity.err_cnt", 32'(ne - e0), 32'd1);
    check("parity.valid_cnt", 32'(nv - v0), 32'd0);
    check_out("parity", 4'd5, 4'd5, 8'h2E);
    send(8'h25, 1'b0, 1'b1);
    check_out("after_parity", 4'd4, 4'd5, 8'h25);
    e0 = ne;
    send(8'h16, 1'b0, 1'b0);
    check("stop.err_cnt", 32'(ne - e0), 32'd1);
    check_out("stop", 4'd4, 4'd5, 8'h25);
    e0 = ne;
    v0 = nv;
    ps2_bit(1'b0);
    for (int i = 0; i < 5; i++) ps2_bit(1'b1);
    ps2_dat = 1'b1;
    repeat (TMO + 1 + 5) @(negedge clk);
    check("timeout.err_cnt", 32'(ne - e0), 32'd1);
    check("timeout.valid_cnt", 32'(nv - v0), 32'd0);
    send(8'h3D, 1'b0, 1'b1);
    check_out("after_timeout", 4'd7, 4'd4, 8'h3D);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    @(negedge clk) rst_n = 1'b0;
    #1;
    check("midframe_reset", {14'd0, dig.o_num1, dig.o_num2, dig.o_scan, dig.o_valid, dig.o_err}, 32'd0);
    ps2_dat = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    v0 = nv;
    send(8'h3E, 1'b0, 1'b1);
    check_out("after_reset", 4'd8, 4'd0, 8'h3E);
    check("after_reset.valid_cnt", 32'(nv - v0), 32'd1);
    check("pulse_shape", 32'(bad), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
